// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard controller.
// Covers the register index width, the XZR index, the forwarding select codes,
// the FSM state codes, the scoreboard entry type and the register-match helpers.
package pipeline_hazard_ctrl_pkg;

  localparam int              REG_W = 5;
  localparam logic [REG_W-1:0] XZR  = 5'd31;

  // EX operand select encodings
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Controller FSM state codes
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } sb_entry_t;

  // X31 reads as zero, so an instruction targeting it never produces a value to wait for.
  function automatic logic is_writer(sb_entry_t e);
    return e.valid & e.reg_write & (e.rd != XZR);
  endfunction

  function automatic logic reads_reg(sb_entry_t e, logic uses, logic [REG_W-1:0] src);
    return uses & is_writer(e) & (src == e.rd);
  endfunction

  // The younger producer (currently in EX) wins over the older one (currently in MEM).
  function automatic logic [1:0] fwd_sel(sb_entry_t ex, sb_entry_t mem, logic uses,
                                         logic [REG_W-1:0] src);
    if (reads_reg(ex, uses, src))       return FWD_MEM;
    else if (reads_reg(mem, uses, src)) return FWD_WB;
    else                                return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Interface between the pipeline stages and the hazard controller.
// master: the pipeline side (drives decode fields and branch outcome, receives controls).
// slave : the controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipeline_hazard_ctrl_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic             id_uses_rn;
  logic             id_uses_rm;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             mem_pc_src;

  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             flush_if;
  logic             flush_id;
  logic             flush_ex;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             startup_busy;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd, id_reg_write,
           id_mem_read, mem_pc_src,
    input  pc_write, ifid_write, idex_bubble, flush_if, flush_id, flush_ex,
           fwd_a, fwd_b, startup_busy, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd, id_reg_write,
           id_mem_read, mem_pc_src,
    output pc_write, ifid_write, idex_bubble, flush_if, flush_id, flush_ex,
           fwd_a, fwd_b, startup_busy, stall_count, flush_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Hazard scoreboard: destination-register entries for the instructions in EX, MEM and WB.
// Latency: entries shift one stage per clock while running; held invalid during startup.
// Backpressure: a stall or flush loads a bubble into EX; a flush also kills the EX->MEM move.
// Ports: clk/reset; i_run (controller running), i_flush, i_ex_load (decode enters EX),
//        i_id_entry (decode instruction); o_ex/o_mem/o_wb current entries.
module pipeline_hazard_ctrl_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_run,
  input  logic      i_flush,
  input  logic      i_ex_load,
  input  sb_entry_t i_id_entry,
  output sb_entry_t o_ex,
  output sb_entry_t o_mem,
  output sb_entry_t o_wb
);

  sb_entry_t r_ex;
  sb_entry_t r_mem;
  sb_entry_t r_wb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!i_run) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      // The instruction already in MEM is past the branch, so it always retires to WB.
      r_wb  <= r_mem;
      r_mem <= i_flush ? '0 : r_ex;
      r_ex  <= i_ex_load ? i_id_entry : '0;
    end
  end

  assign o_ex  = r_ex;
  assign o_mem = r_mem;
  assign o_wb  = r_wb;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// LEGv8 5-stage hazard controller: load-use/WB stalls, branch flushes, EX forwarding selects.
// Latency: stall/flush controls combinational from decode; fwd_a/fwd_b registered as decode enters EX.
// Backpressure: stall holds PC and IF/ID and bubbles EX; a taken branch flushes instead of stalling.
// Ports: clk, reset (async active-low); bus (slave) carries the decode fields, mem_pc_src,
//        the stage enables/flushes, forwarding selects, startup_busy and the two counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int STARTUP_CYCLES = 2,
  parameter bit WB_BYPASS      = 1'b0,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int SC_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'((STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0);

  logic [0:0]       r_state;
  logic [SC_W-1:0]  r_start_cnt;
  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic      w_run;
  logic      w_init_done;
  sb_entry_t w_ex;
  sb_entry_t w_mem;
  sb_entry_t w_wb;
  sb_entry_t w_id_entry;
  logic      w_ex_hit;
  logic      w_wb_hit;
  logic      w_load_use;
  logic      w_wb_haz;
  logic      w_flush;
  logic      w_stall;
  logic      w_ex_load;

  // Startup hold: leave S_INIT on the edge where the counter reaches its last value.
  assign w_init_done = (STARTUP_CYCLES == 0) || (r_start_cnt == SC_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_INIT;
      r_start_cnt <= '0;
    end else if (r_state == S_INIT) begin
      r_start_cnt <= r_start_cnt + 1'b1;
      if (w_init_done) r_state <= S_RUN;
    end
  end

  assign w_run = (r_state == S_RUN);

  assign w_id_entry = '{valid: 1'b1, rd: bus.id_rd, reg_write: bus.id_reg_write,
                        mem_read: bus.id_mem_read};

  assign w_ex_hit = reads_reg(w_ex, bus.id_uses_rn, bus.id_rn) |
                    reads_reg(w_ex, bus.id_uses_rm, bus.id_rm);
  assign w_wb_hit = reads_reg(w_wb, bus.id_uses_rn, bus.id_rn) |
                    reads_reg(w_wb, bus.id_uses_rm, bus.id_rm);

  assign w_load_use = w_run & bus.id_valid & w_ex_hit & w_ex.mem_read;
  // Without a write-through register file the decode read would see the stale value.
  assign w_wb_haz   = w_run & bus.id_valid & ~WB_BYPASS & w_wb_hit;
  assign w_flush    = w_run & bus.mem_pc_src;
  // A taken branch squashes the stalled instruction anyway, so it overrides the stall.
  assign w_stall    = (w_load_use | w_wb_haz) & ~bus.mem_pc_src;
  assign w_ex_load  = w_run & bus.id_valid & ~w_stall & ~w_flush;

  pipeline_hazard_ctrl_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_run      (w_run),
    .i_flush    (w_flush),
    .i_ex_load  (w_ex_load),
    .i_id_entry (w_id_entry),
    .o_ex       (w_ex),
    .o_mem      (w_mem),
    .o_wb       (w_wb)
  );

  // Selects are computed against the entries the decode instruction will trail by one and two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else if (w_ex_load) begin
      r_fwd_a <= fwd_sel(w_ex, w_mem, bus.id_uses_rn, bus.id_rn);
      r_fwd_b <= fwd_sel(w_ex, w_mem, bus.id_uses_rm, bus.id_rm);
    end else begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.pc_write     = w_run & ~w_stall;
  assign bus.ifid_write   = w_run & ~w_stall;
  assign bus.idex_bubble  = ~w_run | w_stall | w_flush;
  assign bus.flush_if     = w_flush;
  assign bus.flush_id     = w_flush;
  assign bus.flush_ex     = w_flush;
  assign bus.fwd_a        = r_fwd_a;
  assign bus.fwd_b        = r_fwd_b;
  assign bus.startup_busy = ~w_run;
  assign bus.stall_count  = r_stall_cnt;
  assign bus.flush_count  = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (no WB bypass with 16-bit counters,
// WB bypass with 8-bit counters so saturation is reachable) driven with identical stimulus
// and compared every cycle against a pipeline-occupancy reference model.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus0 ();
  pipeline_hazard_ctrl_if #(.CNT_W(8))  bus1 ();

  pipeline_hazard_ctrl #(.STARTUP_CYCLES(2), .WB_BYPASS(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  pipeline_hazard_ctrl #(.STARTUP_CYCLES(2), .WB_BYPASS(1'b1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  // Reference model: what each pipeline stage holds, as plain records.
  typedef struct { bit v; int rd; bit rw; bit mr; } ment_t;
  ment_t e0 = '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
  ment_t m_ex[2], m_mem[2], m_wb[2];
  int    m_fa[2], m_fb[2], m_sc[2], m_fc[2];
  int    m_since;
  int    SAT[2] = '{65535, 255};
  bit    BYP[2] = '{1'b0, 1'b1};

  bit c_idv, c_urn, c_urm, c_rw, c_mr, c_pc;
  int c_rn, c_rm, c_rd;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, obs, exp);
    end
  endtask

  function automatic bit m_writer(ment_t e);
    return e.v && e.rw && (e.rd != 31);
  endfunction

  function automatic bit m_reads(ment_t e, bit u, int r);
    return u && m_writer(e) && (r == e.rd);
  endfunction

  task automatic m_reset();
    m_since = 0;
    for (int i = 0; i < 2; i++) begin
      m_ex[i] = e0; m_mem[i] = e0; m_wb[i] = e0;
      m_fa[i] = 0; m_fb[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask

  task automatic m_eval(input int i, output bit run, output bit stall, output bit flush);
    bit lu, wbh;
    run   = (m_since >= 2);
    lu    = run && c_idv && m_ex[i].mr &&
            (m_reads(m_ex[i], c_urn, c_rn) || m_reads(m_ex[i], c_urm, c_rm));
    wbh   = run && c_idv && !BYP[i] &&
            (m_reads(m_wb[i], c_urn, c_rn) || m_reads(m_wb[i], c_urm, c_rm));
    flush = run && c_pc;
    stall = (lu || wbh) && !c_pc;
  endtask

  task automatic m_advance();
    bit run, stall, flush;
    ment_t nw;
    for (int i = 0; i < 2; i++) begin
      m_eval(i, run, stall, flush);
      if (!run) begin
        m_ex[i] = e0; m_mem[i] = e0; m_wb[i] = e0; m_fa[i] = 0; m_fb[i] = 0;
      end else begin
        if (c_idv && !stall && !flush) begin
          m_fa[i] = m_reads(m_ex[i], c_urn, c_rn) ? 2 : (m_reads(m_mem[i], c_urn, c_rn) ? 1 : 0);
          m_fb[i] = m_reads(m_ex[i], c_urm, c_rm) ? 2 : (m_reads(m_mem[i], c_urm, c_rm) ? 1 : 0);
          nw = '{v: 1'b1, rd: c_rd, rw: c_rw, mr: c_mr};
        end else begin
          m_fa[i] = 0; m_fb[i] = 0; nw = e0;
        end
        m_wb[i]  = m_mem[i];
        m_mem[i] = flush ? e0 : m_ex[i];
        m_ex[i]  = nw;
        if (stall && m_sc[i] < SAT[i]) m_sc[i]++;
        if (flush && m_fc[i] < SAT[i]) m_fc[i]++;
      end
    end
    m_since++;
  endtask

  task automatic check_cycle();
    bit run, stall, flush;
    logic [31:0] pcw, ifw, bub, fl, fa, fb, bz, sc, fc;
    for (int i = 0; i < 2; i++) begin
      m_eval(i, run, stall, flush);
      if (i == 0) begin
        pcw = 32'(bus0.pc_write); ifw = 32'(bus0.ifid_write); bub = 32'(bus0.idex_bubble);
        fl  = 32'({bus0.flush_if, bus0.flush_id, bus0.flush_ex});
        fa  = 32'(bus0.fwd_a); fb = 32'(bus0.fwd_b); bz = 32'(bus0.startup_busy);
        sc  = 32'(bus0.stall_count); fc = 32'(bus0.flush_count);
      end else begin
        pcw = 32'(bus1.pc_write); ifw = 32'(bus1.ifid_write); bub = 32'(bus1.idex_bubble);
        fl  = 32'({bus1.flush_if, bus1.flush_id, bus1.flush_ex});
        fa  = 32'(bus1.fwd_a); fb = 32'(bus1.fwd_b); bz = 32'(bus1.startup_busy);
        sc  = 32'(bus1.stall_count); fc = 32'(bus1.flush_count);
      end
      chk("pc_write",     i, pcw, 32'(run && !stall));
      chk("ifid_write",   i, ifw, 32'(run && !stall));
      chk("idex_bubble",  i, bub, 32'(!run || stall || c_pc));
      chk("flush_if_id_ex", i, fl, flush ? 32'd7 : 32'd0);
      chk("fwd_a",        i, fa, 32'(m_fa[i]));
      chk("fwd_b",        i, fb, 32'(m_fb[i]));
      chk("startup_busy", i, bz, 32'(!run));
      chk("stall_count",  i, sc, 32'(m_sc[i]));
      chk("flush_count",  i, fc, 32'(m_fc[i]));
    end
  endtask

  task automatic drive(input bit idv, input bit urn, input int rn, input bit urm, input int rm,
                       input int rd, input bit rw, input bit mr, input bit pc);
    c_idv = idv; c_urn = urn; c_rn = rn; c_urm = urm; c_rm = rm;
    c_rd = rd; c_rw = rw; c_mr = mr; c_pc = pc;
    bus0.id_valid = idv; bus0.id_uses_rn = urn; bus0.id_rn = 5'(rn); bus0.id_uses_rm = urm;
    bus0.id_rm = 5'(rm); bus0.id_rd = 5'(rd); bus0.id_reg_write = rw; bus0.id_mem_read = mr;
    bus0.mem_pc_src = pc;
    bus1.id_valid = idv; bus1.id_uses_rn = urn; bus1.id_rn = 5'(rn); bus1.id_uses_rm = urm;
    bus1.id_rm = 5'(rm); bus1.id_rd = 5'(rd); bus1.id_reg_write = rw; bus1.id_mem_read = mr;
    bus1.mem_pc_src = pc;
  endtask

  // One pipeline cycle: present decode, check outputs, clock, update the model.
  task automatic step(input bit idv, input bit urn, input int rn, input bit urm, input int rm,
                      input int rd, input bit rw, input bit mr, input bit pc);
    drive(idv, urn, rn, urm, rm, rd, rw, mr, pc);
    #1;
    check_cycle();
    @(posedge clk);
    #1;
    m_advance();
  endtask

  function automatic int pick_reg();
    return ($urandom_range(0, 4) == 0) ? 31 : int'($urandom_range(1, 4));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_cycle();                          // reset values while reset held
    reset = 1'b1;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0);        // startup hold cycle 1
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);        // startup hold cycle 2

    // Load X2 then ADD X3,X2,X4: one load-use stall, then MEM forward on A.
    step(1, 0, 0, 0, 0, 2, 1, 1, 0);
    step(1, 1, 2, 1, 4, 3, 1, 0, 0);
    chk("plan_loaduse_stall_count", 0, 32'(bus0.stall_count), 32'd1);
    step(1, 1, 2, 1, 4, 3, 1, 0, 0);
    chk("plan_loaduse_fwd_a", 0, 32'(bus0.fwd_a), 32'd1);
    // SUB X6,X3,X1 right behind ADD X3: EX forward, no stall.
    step(1, 1, 3, 1, 1, 6, 1, 0, 0);
    chk("plan_ex_fwd_a", 1, 32'(bus1.fwd_a), 32'd2);
    // Producer of X31, consumer of X31: never forwarded.
    step(1, 1, 1, 0, 0, 31, 1, 0, 0);
    step(1, 1, 31, 0, 0, 8, 1, 0, 0);
    chk("plan_xzr_fwd_a", 0, 32'(bus0.fwd_a), 32'd0);

    // Taken branch coinciding with a load-use hazard.
    step(1, 0, 0, 0, 0, 2, 1, 1, 0);
    step(1, 1, 2, 0, 0, 9, 1, 0, 1);
    chk("plan_flush_count", 0, 32'(bus0.flush_count), 32'd1);
    chk("plan_flush_no_stall", 0, 32'(bus0.stall_count), 32'd1);
    step(1, 1, 2, 0, 0, 9, 1, 0, 0);        // EX/MEM now empty: no stall, no forward
    chk("plan_postflush_fwd_a", 0, 32'(bus0.fwd_a), 32'd0);

    // WB-stage producer X7 two bubbles ahead of a reader of X7.
    step(1, 0, 0, 0, 0, 7, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 7, 0, 0, 10, 1, 0, 0);
    chk("plan_wb_stall_nobypass", 0, 32'(bus0.stall_count), 32'd2);
    chk("plan_wb_nostall_bypass", 1, 32'(bus1.stall_count), 32'd1);
    step(1, 1, 7, 0, 0, 10, 1, 0, 0);
    chk("plan_wb_stall_once", 0, 32'(bus0.stall_count), 32'd2);

    // Randomized traffic over a small register set to provoke hazards.
    for (int n = 0; n < 300; n++) begin
      step(bit'($urandom_range(0, 7) != 0), bit'($urandom_range(0, 1)), pick_reg(),
           bit'($urandom_range(0, 1)), pick_reg(), pick_reg(), bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 9) == 0));
    end

    // Reset asserted in the middle of a load-use stall.
    step(1, 0, 0, 0, 0, 2, 1, 1, 0);
    drive(1, 1, 2, 0, 0, 3, 1, 0, 0);
    #1;
    check_cycle();
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    check_cycle();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1, 1, 2, 0, 0, 3, 1, 0, 0);        // startup hold re-runs
    step(1, 1, 2, 0, 0, 3, 1, 0, 0);
    step(1, 1, 2, 0, 0, 3, 1, 0, 0);

    // Repeated load-use pairs until the narrow counter saturates.
    for (int n = 0; n < 400; n++) begin
      step(1, 0, 0, 0, 0, 2, 1, 1, 0);
      step(1, 1, 2, 0, 0, 3, 1, 0, 0);
      step(1, 1, 2, 0, 0, 3, 1, 0, 0);
    end
    chk("plan_stall_saturate", 1, 32'(bus1.stall_count), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage LEGv8 pipeline (fetch, decode, execute, memory, write-back).
- Keeps a registered scoreboard of destination registers for the instructions in EX, MEM and WB.
- From that scoreboard it produces load-use and write-back stalls, branch flushes and EX-stage forwarding selects.
- Holds the pipeline idle for a fixed number of cycles after reset.
- Sits beside the stage modules and drives their write-enable and flush inputs.

Parameters:
STARTUP_CYCLES, 2, cycles after reset release with fetch held and bubbles injected.
WB_BYPASS, 0, 1 means the register file forwards WB write data to same-cycle reads; 0 means a WB match stalls decode.
CNT_W, 16, width of the saturating stall and flush counters.

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
id_valid  in  1  decode holds a real instruction.
id_rn  in  5  first source register of the decode instruction.
id_rm  in  5  second source register of the decode instruction.
id_uses_rn  in  1  decode instruction reads id_rn.
id_uses_rm  in  1  decode instruction reads id_rm.
id_rd  in  5  destination register of the decode instruction.
id_reg_write  in  1  decode instruction writes id_rd.
id_mem_read  in  1  decode instruction is a load.
mem_pc_src  in  1  branch resolved taken in the memory stage.
pc_write  out  1  PC update enable.
ifid_write  out  1  IF/ID register enable.
idex_bubble  out  1  zero the control signals entering EX.
flush_if  out  1  squash the fetch stage.
flush_id  out  1  squash the decode stage.
flush_ex  out  1  squash the execute stage.
fwd_a  out  2  EX operand A select: 00 register file, 01 WB write data, 10 MEM ALU result.
fwd_b  out  2  EX operand B select, same encoding as fwd_a.
startup_busy  out  1  startup hold is active.
stall_count  out  CNT_W  stall cycles, saturating.
flush_count  out  CNT_W  taken-branch flushes, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=S_INIT, startup counter=0.
  - Scoreboard EX/MEM/WB entries invalid.
  - fwd_a=fwd_b=00, both counters 0.
  - Combinational outputs while in reset or S_INIT: pc_write=0, ifid_write=0, idex_bubble=1, flush_*=0, startup_busy=1.
- Scoreboard entry = {valid, rd, reg_write, mem_read}.
  - An entry is a "writer" when valid & reg_write & rd!=31; X31/XZR never matches.
- FSM:
  - S_INIT: counter increments each cycle; moves to S_RUN on the edge where counter==STARTUP_CYCLES-1, or on the first edge when STARTUP_CYCLES=0.
  - S_RUN: terminal. Reset asserted mid-operation returns to S_INIT immediately.
- Hazards, evaluated in S_RUN with id_valid=1:
  - src_match(e) = (id_uses_rn & rn==e.rd) | (id_uses_rm & rm==e.rd), with e a writer.
  - load_use = src_match(EX entry) & EX.mem_read.
  - wb_hazard = (WB_BYPASS==0) & src_match(WB entry).
  - stall = (load_use | wb_hazard) & !mem_pc_src.
- Flush: when mem_pc_src=1, flush_if=flush_id=flush_ex=1 in the same cycle. pc_write=1 so the branch target loads.
- Outputs in S_RUN:
  - pc_write = ifid_write = !stall.
  - idex_bubble = stall | mem_pc_src.
- Scoreboard advance, every edge in S_RUN:
  - WB <= MEM.
  - MEM <= flush ? invalid : EX.
  - EX <= (stall | flush | !id_valid) ? invalid : {1, id_rd, id_reg_write, id_mem_read}.
  - In S_INIT all entries are held invalid.
- Forwarding, registered on the same edge the decode instruction enters EX:
  - Priority: a match with the current EX entry gives 10; else a match with the current MEM entry gives 01; else 00. Computed per operand, and only when the corresponding id_uses_* is set.
  - When EX is loaded with a bubble, fwd_a=fwd_b=00.
- Counters:
  - stall_count increments on each cycle with stall=1.
  - flush_count increments on each cycle with mem_pc_src=1 in S_RUN.
  - Both hold at all-ones.
- Flush has priority over stall when both occur.

Decomposition:
- Add to definitions.vh:
  - register index width (5) and XZR constant 31.
  - forwarding encodings FWD_RF/FWD_WB/FWD_MEM.
  - FSM state codes.
- One natural sub-module: hazard_scoreboard. It holds the EX/MEM/WB entries, their advance and flush logic, and exposes the entries to the comparison logic.

Test Plan:
- Reset release with STARTUP_CYCLES=2: startup_busy=1 and pc_write=0 for exactly 2 cycles, then pc_write=1; fwd_a/fwd_b=00.
- Load X2 (EX) followed by ADD X3,X2,X4 in decode: one cycle with pc_write=0, idex_bubble=1, stall_count=1. Next cycle the ADD enters EX with fwd_a=01.
- ADD X5 then SUB reading X5: no stall, fwd_a=10. Producer writing X31 with consumer reading X31: fwd_a=00.
- mem_pc_src=1 coinciding with a load-use condition: flush_*=1, pc_write=1, no stall, flush_count increments, EX/MEM entries invalid on the next cycle.
- WB_BYPASS=0 with the WB entry writing X7 and decode reading X7: exactly 1 stall cycle. With WB_BYPASS=1: no stall.
- Assert reset during a stall: outputs return to reset values asynchronously and the FSM re-runs the startup hold. Force 2^CNT_W stalls: stall_count saturates at 0xFFFF.
